// File: rtl/wb_arbiter.sv
// Write-back arbiter: three per-unit result FIFOs share one registered register-file write port.
// Define WB_RR_EN for round-robin arbitration; default is fixed MEM > MUL > ALU priority.

module wb_arbiter_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         ready,
  output logic         nempty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [PW-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + PW'(1);
    end
    if (pop) rd_d = rd_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout   = mem_q[rd_q];
  assign ready  = cnt_q < CW'(DEPTH);
  assign nempty = cnt_q != '0;
endmodule

module wb_arbiter #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_wb_valid,
  input  logic              alu_wb_writereg,
  input  logic [ADDR_W-1:0] alu_wb_regdest,
  input  logic [DATA_W-1:0] alu_wb_data,
  output logic              alu_wb_ready,
  input  logic              mem_wb_valid,
  input  logic              mem_wb_writereg,
  input  logic [ADDR_W-1:0] mem_wb_regdest,
  input  logic [DATA_W-1:0] mem_wb_data,
  output logic              mem_wb_ready,
  input  logic              mul_wb_valid,
  input  logic              mul_wb_writereg,
  input  logic [ADDR_W-1:0] mul_wb_regdest,
  input  logic [DATA_W-1:0] mul_wb_data,
  output logic              mul_wb_ready,
  output logic              wb_reg_we,
  output logic [ADDR_W-1:0] wb_reg_addr,
  output logic [DATA_W-1:0] wb_reg_data,
  output logic              wb_sb_clr,
  output logic [ADDR_W-1:0] wb_sb_addr,
  output logic [1:0]        wb_grant,
  output logic              wb_busy
);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_ent_t;
  localparam int EW = $bits(wb_ent_t);

  // Lane index 0/1/2 = ALU/MEM/MUL; unit code = index + 1.
  logic [2:0]             in_vld, in_wr, rdy, ne, push, pop;
  logic [2:0][ADDR_W-1:0] in_rd;
  logic [2:0][DATA_W-1:0] in_dat;
  logic [2:0][EW-1:0]     head;

  assign in_vld = {mul_wb_valid, mem_wb_valid, alu_wb_valid};
  assign in_wr  = {mul_wb_writereg, mem_wb_writereg, alu_wb_writereg};
  assign in_rd  = {mul_wb_regdest, mem_wb_regdest, alu_wb_regdest};
  assign in_dat = {mul_wb_data, mem_wb_data, alu_wb_data};

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_lane
      // Results without a real destination complete the handshake but are dropped.
      assign push[g] = in_vld[g] && rdy[g] && in_wr[g] && (in_rd[g] != '0);
      wb_arbiter_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push[g]),
        .pop   (pop[g]),
        .din   ({in_rd[g], in_dat[g]}),
        .dout  (head[g]),
        .ready (rdy[g]),
        .nempty(ne[g])
      );
    end
  endgenerate

  assign alu_wb_ready = rdy[0];
  assign mem_wb_ready = rdy[1];
  assign mul_wb_ready = rdy[2];
  assign wb_busy      = |ne;

  logic       gnt_vld;
  logic [1:0] gnt_idx;

`ifdef WB_RR_EN
  logic [1:0] lg_q, lg_d;
  logic [1:0] c;

  // Scan ALU -> MEM -> MUL starting just after the last granted unit.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    c       = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      c = 2'((int'(lg_q) - 1 + k) % 3);
      if (!gnt_vld && ne[c]) begin
        gnt_vld = 1'b1;
        gnt_idx = c;
      end
    end
    lg_d = gnt_vld ? gnt_idx + 2'd1 : lg_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) lg_q <= 2'b01;
    else       lg_q <= lg_d;
  end
`else
  always_comb begin
    gnt_vld = |ne;
    if (ne[1])      gnt_idx = 2'd1;
    else if (ne[2]) gnt_idx = 2'd2;
    else            gnt_idx = 2'd0;
  end
`endif

  assign pop = gnt_vld ? (3'b001 << gnt_idx) : 3'b000;

  wb_ent_t           hd;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        grant_q, grant_d;

  always_comb begin
    hd      = wb_ent_t'(head[gnt_idx]);
    we_d    = gnt_vld;
    addr_d  = gnt_vld ? hd.addr : addr_q;
    data_d  = gnt_vld ? hd.data : data_q;
    grant_d = gnt_vld ? gnt_idx + 2'd1 : 2'b00;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      grant_q <= 2'b00;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      grant_q <= grant_d;
    end
  end

  assign wb_reg_we   = we_q;
  assign wb_reg_addr = addr_q;
  assign wb_reg_data = data_q;
  assign wb_sb_clr   = we_q;
  assign wb_sb_addr  = addr_q;
  assign wb_grant    = grant_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized + directed bench for wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
  localparam int DEPTH = 2, DW = 32, AW = 5;

  logic clock = 1'b0, reset = 1'b1;
  always #5 clock = ~clock;

  logic          v [3], wr [3];
  logic [AW-1:0] rd [3];
  logic [DW-1:0] dt [3];
  logic          acc [3];

  logic          alu_rdy, mem_rdy, mul_rdy, we, clr, busy;
  logic [AW-1:0] waddr, sbaddr;
  logic [DW-1:0] wdata;
  logic [1:0]    grant;

  wb_arbiter #(.DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset),
    .alu_wb_valid(v[0]), .alu_wb_writereg(wr[0]), .alu_wb_regdest(rd[0]), .alu_wb_data(dt[0]), .alu_wb_ready(alu_rdy),
    .mem_wb_valid(v[1]), .mem_wb_writereg(wr[1]), .mem_wb_regdest(rd[1]), .mem_wb_data(dt[1]), .mem_wb_ready(mem_rdy),
    .mul_wb_valid(v[2]), .mul_wb_writereg(wr[2]), .mul_wb_regdest(rd[2]), .mul_wb_data(dt[2]), .mul_wb_ready(mul_rdy),
    .wb_reg_we(we), .wb_reg_addr(waddr), .wb_reg_data(wdata), .wb_sb_clr(clr), .wb_sb_addr(sbaddr),
    .wb_grant(grant), .wb_busy(busy)
  );

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t q [3][$];
  int   last;
  logic          e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [1:0]    e_grant;
  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick();
`ifdef WB_RR_EN
    for (int k = 1; k <= 3; k++) begin
      int u = (last - 1 + k) % 3;
      if (q[u].size() != 0) return u + 1;
    end
`else
    if (q[1].size() != 0) return 2;
    if (q[2].size() != 0) return 3;
    if (q[0].size() != 0) return 1;
`endif
    return 0;
  endfunction

  function automatic logic dut_rdy(input int u);
    return (u == 0) ? alu_rdy : (u == 1) ? mem_rdy : mul_rdy;
  endfunction

  // One clock: check pre-edge status, advance the model, then check registered outputs.
  task automatic step();
    int g;
    logic r [3];
    ent_t e;
    for (int u = 0; u < 3; u++) begin
      r[u] = q[u].size() < DEPTH;
      chk($sformatf("ready%0d", u), dut_rdy(u), r[u]);
    end
    chk("busy", busy, (q[0].size() + q[1].size() + q[2].size()) != 0);
    g = pick();
    if (g != 0) begin
      e = q[g-1].pop_front();
      e_we = 1'b1; e_addr = e.a; e_data = e.d; e_grant = 2'(g); last = g;
    end else begin
      e_we = 1'b0; e_grant = 2'b00;
    end
    for (int u = 0; u < 3; u++) begin
      acc[u] = v[u] && r[u];
      if (acc[u] && wr[u] && rd[u] != 0) q[u].push_back('{a: rd[u], d: dt[u]});
    end
    @(posedge clock); #1;
    chk("we", we, e_we);
    chk("clr", clr, e_we);
    chk("addr", waddr, e_addr);
    chk("sbaddr", sbaddr, e_addr);
    chk("data", wdata, e_data);
    chk("grant", grant, e_grant);
  endtask

  task automatic set(input int u, input logic vv, input logic ww, input logic [AW-1:0] rr, input logic [DW-1:0] dd);
    v[u] = vv; wr[u] = ww; rd[u] = rr; dt[u] = dd;
  endtask

  // Offer a new transaction only if the previous one was taken (or none was pending).
  task automatic offer(input int u, input logic vv, input logic ww, input logic [AW-1:0] rr, input logic [DW-1:0] dd);
    if (!v[u] || acc[u]) set(u, vv, ww, rr, dd);
  endtask

  task automatic idle();
    for (int u = 0; u < 3; u++) begin set(u, 1'b0, 1'b0, '0, '0); acc[u] = 1'b0; end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 3; u++) q[u].delete();
    last = 1; e_we = 1'b0; e_addr = '0; e_data = '0; e_grant = 2'b00;
  endtask

  task automatic chk_rst_outs(input string tag);
    chk({tag, "_we"}, we, 1'b0);
    chk({tag, "_clr"}, clr, 1'b0);
    chk({tag, "_addr"}, waddr, '0);
    chk({tag, "_data"}, wdata, '0);
    chk({tag, "_grant"}, grant, 2'b00);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    idle();
    model_reset();
    #1 chk_rst_outs("rst");
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;

    // Single ALU push, r3 = 0xAA
    set(0, 1'b1, 1'b1, 5'd3, 32'h0000_00AA);
    step(); idle();
    repeat (3) step();

    // Simultaneous push from all three units
    set(0, 1'b1, 1'b1, 5'd1, 32'h11);
    set(1, 1'b1, 1'b1, 5'd2, 32'h22);
    set(2, 1'b1, 1'b1, 5'd3, 32'h33);
    step(); idle();
    repeat (4) step();

    // All units continuously valid: backpressure and arbitration order
    for (int i = 0; i < 12; i++) begin
      for (int u = 0; u < 3; u++) offer(u, 1'b1, 1'b1, 5'(1 + u * 10 + (i % 9)), 32'(u * 1000 + i));
      step();
    end
    idle();
    repeat (8) step();

    // Filtered pushes: regdest=0 and writereg=0
    set(0, 1'b1, 1'b1, 5'd0, 32'hDEAD);
    set(1, 1'b1, 1'b0, 5'd7, 32'hBEEF);
    step(); idle();
    repeat (3) step();

    // Async reset with queued entries
    for (int i = 0; i < 4; i++) begin
      for (int u = 0; u < 3; u++) offer(u, 1'b1, 1'b1, 5'(4 + u + i), 32'(32'hC0 + u * 16 + i));
      step();
    end
    idle();
    #2 reset = 1'b1;
    #1 chk_rst_outs("arst");
    model_reset();
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
    chk_rst_outs("post");
    set(0, 1'b1, 1'b1, 5'd9, 32'h1234_5678);
    step(); idle();
    repeat (3) step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      for (int u = 0; u < 3; u++)
        offer(u, $urandom_range(0, 99) < 60, $urandom_range(0, 9) != 0,
              5'($urandom_range(0, 31)), $urandom);
      step();
    end
    idle();
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
